// File: rtl/link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : link_arbiter
//  Description : Round-robin arbiter that shares one downstream rq/ak serial
//                link between N upstream senders. Each sender keeps its own
//                four-phase rq/ak handshake. The arbiter runs the same
//                handshake toward the link for one granted sender at a time.
//                Optional feature macro: ARB_TIMEOUT_EN. When it is defined,
//                a stuck link_ak aborts the transaction after TO_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module link_arbiter #(
    parameter int N         = 4,
    parameter int TO_CYCLES = 255,
    parameter int TW        = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_rq,
    input  logic [N-1:0] req_d,
    output logic [N-1:0] req_ak,
    output logic         link_rq,
    output logic         link_d,
    input  logic         link_ak,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         timeout_err
);

    localparam int c_IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_AKH  = 3'd1;
    localparam logic [2:0] c_AKL  = 3'd2;
    localparam logic [2:0] c_RQL  = 3'd3;
`ifdef ARB_TIMEOUT_EN
    localparam logic [2:0] c_ABT  = 3'd4;
`endif

    localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(N - 1);
    localparam logic [N-1:0]    c_ONE      = {{(N-1){1'b0}}, 1'b1};

    // Reject configurations the counter or the pointer cannot represent.
    if ((N < 2) || (N > 8) || (TO_CYCLES < 1) || (TO_CYCLES >= (1 << TW))) begin : g_bad_cfg
        $error("link_arbiter: illegal parameter combination");
    end

    logic [2:0]      r_state;
    logic [c_IW-1:0] r_last;
    logic [c_IW-1:0] r_win;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    r_req_ak;
    logic            r_link_rq;
    logic            r_link_d;

    logic            w_any;
    logic [c_IW-1:0] w_pick;

`ifdef ARB_TIMEOUT_EN
    logic [TW-1:0]   r_cnt;
    logic            r_timeout_err;
`endif

    // Round-robin pick: first asserted requester after the last one served.
    // The scan ends on the last-served requester, so a lone repeat requester wins.
    always_comb begin
        int v_idx;
        w_any  = 1'b0;
        w_pick = '0;
        v_idx  = 0;
        for (int i = 1; i <= N; i++) begin
            v_idx = (int'(r_last) + i) % N;
            if (!w_any && req_rq[v_idx]) begin
                w_any  = 1'b1;
                w_pick = v_idx[c_IW-1:0];
            end
        end
    end

    // Handshake FSM. All link-side and sender-side outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_last    <= c_LAST_RST;
            r_win     <= '0;
            r_grant   <= '0;
            r_req_ak  <= '0;
            r_link_rq <= 1'b0;
            r_link_d  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_win     <= w_pick;
                        r_grant   <= c_ONE << w_pick;
                        // The data bit is captured once; later req_d changes are ignored.
                        r_link_d  <= req_d[w_pick];
                        r_link_rq <= 1'b1;
                        r_state   <= c_AKH;
`ifdef ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end
                c_AKH: begin
                    if (link_ak) begin
                        r_req_ak[r_win] <= 1'b1;
                        r_state         <= c_AKL;
                    end
`ifdef ARB_TIMEOUT_EN
                    // The abort fires on the edge at which the count would reach TO_CYCLES.
                    else if (r_cnt == TW'(TO_CYCLES - 1)) begin
                        r_link_rq       <= 1'b0;
                        r_req_ak[r_win] <= 1'b1;
                        r_timeout_err   <= 1'b1;
                        r_state         <= c_ABT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                c_AKL: begin
                    if (!link_ak) begin
                        r_req_ak[r_win] <= 1'b0;
                        r_state         <= c_RQL;
                    end
                end
                c_RQL: begin
                    // An early req_rq drop by the owner lands here and releases at once.
                    if (!req_rq[r_win]) begin
                        r_link_rq <= 1'b0;
                        r_grant   <= '0;
                        r_last    <= r_win;
                        r_state   <= c_IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                c_ABT: begin
                    r_req_ak[r_win] <= 1'b0;
                    r_timeout_err   <= 1'b0;
                    r_state         <= c_RQL;
                end
`endif
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ak  = r_req_ak;
    assign link_rq = r_link_rq;
    assign link_d  = r_link_d;
    assign grant   = r_grant;
    assign busy    = (r_state != c_IDLE);

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_link_arbiter
//  Description : Directed, table-driven self-checking bench for link_arbiter
//                (N=4, TO_CYCLES=10). Optional macro: ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_link_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_rq;
    logic [3:0] req_d;
    logic [3:0] req_ak;
    logic       link_rq;
    logic       link_d;
    logic       link_ak;
    logic [3:0] grant;
    logic       busy;
    logic       timeout_err;

    int n_tests;
    int n_fail;

    link_arbiter #(.N(4), .TO_CYCLES(10), .TW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_rq      (req_rq),
        .req_d       (req_d),
        .req_ak      (req_ak),
        .link_rq     (link_rq),
        .link_d      (link_d),
        .link_ak     (link_ak),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] rq;
        logic [3:0] d;
        logic       ak;
        logic [3:0] e_grant;
        logic [3:0] e_ack;
        logic       e_lrq;
        logic       e_ld;
        logic       e_busy;
    } vec_t;

    vec_t tbl [32];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [3:0] e;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        req_rq  = 4'b0;
        req_d   = 4'b0;
        link_ak = 1'b0;

        //         rst  rq       d        ak    grant    ack      lrq   ld    busy
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 4'b1000, 4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1};
        tbl[22] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[23] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1};
        tbl[25] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1};
        tbl[26] = '{1'b0, 4'b1000, 4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1};
        tbl[27] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[28] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[29] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1};
        tbl[30] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[31] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};

        // Table: reset, single request, data capture, early drop, repeat owner, early ak.
        for (int i = 0; i < 32; i++) begin
            rst     = tbl[i].rst;
            req_rq  = tbl[i].rq;
            req_d   = tbl[i].d;
            link_ak = tbl[i].ak;
            step();
            chk($sformatf("v%0d.grant", i),   {4'b0, grant},       {4'b0, tbl[i].e_grant});
            chk($sformatf("v%0d.req_ak", i),  {4'b0, req_ak},      {4'b0, tbl[i].e_ack});
            chk($sformatf("v%0d.link_rq", i), {7'b0, link_rq},     {7'b0, tbl[i].e_lrq});
            chk($sformatf("v%0d.busy", i),    {7'b0, busy},        {7'b0, tbl[i].e_busy});
            chk($sformatf("v%0d.tmo", i),     {7'b0, timeout_err}, 8'h00);
            if (tbl[i].e_busy || tbl[i].rst)
                chk($sformatf("v%0d.link_d", i), {7'b0, link_d}, {7'b0, tbl[i].e_ld});
        end

        // Stuck link_ak.
        req_rq  = 4'b0100;
        req_d   = 4'b0000;
        link_ak = 1'b0;
        step();
        chk("to.grant", {4'b0, grant}, 8'h04);
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 9; c++) begin
            step();
            chk($sformatf("to.c%0d.lrq", c), {7'b0, link_rq}, 8'h01);
            chk($sformatf("to.c%0d.tmo", c), {7'b0, timeout_err}, 8'h00);
        end
        step();
        chk("to.abort.lrq", {7'b0, link_rq}, 8'h00);
        chk("to.abort.ack", {4'b0, req_ak}, 8'h04);
        chk("to.abort.tmo", {7'b0, timeout_err}, 8'h01);
        step();
        chk("to.abt.ack", {4'b0, req_ak}, 8'h00);
        chk("to.abt.tmo", {7'b0, timeout_err}, 8'h00);
        chk("to.abt.busy", {7'b0, busy}, 8'h01);
        req_rq = 4'b0000;
        step();
        chk("to.rel.busy", {7'b0, busy}, 8'h00);
        chk("to.rel.grant", {4'b0, grant}, 8'h00);
`else
        for (int c = 1; c <= 20; c++) begin
            step();
            chk($sformatf("to.c%0d.busy", c), {7'b0, busy}, 8'h01);
            chk($sformatf("to.c%0d.lrq", c), {7'b0, link_rq}, 8'h01);
            chk($sformatf("to.c%0d.tmo", c), {7'b0, timeout_err}, 8'h00);
            chk($sformatf("to.c%0d.ack", c), {4'b0, req_ak}, 8'h00);
        end
        link_ak = 1'b1;
        step();
        chk("to.late.ack", {4'b0, req_ak}, 8'h04);
        link_ak = 1'b0;
        step();
        req_rq = 4'b0000;
        step();
        chk("to.rel.busy", {7'b0, busy}, 8'h00);
`endif

        // Round-robin over five back-to-back transactions with every requester active.
        rst     = 1'b1;
        req_rq  = 4'b1111;
        req_d   = 4'b1010;
        link_ak = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            step();
            chk($sformatf("rr%0d.grant", k), {4'b0, grant}, {4'b0, e});
            chk($sformatf("rr%0d.busy", k), {7'b0, busy}, 8'h01);
            chk($sformatf("rr%0d.link_d", k), {7'b0, link_d}, {7'b0, |(e & 4'b1010)});
            link_ak = 1'b1;
            step();
            chk($sformatf("rr%0d.ack", k), {4'b0, req_ak}, {4'b0, e});
            link_ak = 1'b0;
            step();
            req_rq = 4'b1111 & ~e;
            step();
            chk($sformatf("rr%0d.idle", k), {7'b0, busy}, 8'h00);
            chk($sformatf("rr%0d.rel", k), {4'b0, grant}, 8'h00);
            req_rq = 4'b1111;
        end
        req_rq = 4'b0000;
        step();

        // Reset while in AKL.
        req_rq  = 4'b0100;
        req_d   = 4'b0100;
        step();
        link_ak = 1'b1;
        step();
        chk("rst.akl.ack", {4'b0, req_ak}, 8'h04);
        rst = 1'b1;
        step();
        chk("rst.lrq", {7'b0, link_rq}, 8'h00);
        chk("rst.ack", {4'b0, req_ak}, 8'h00);
        chk("rst.grant", {4'b0, grant}, 8'h00);
        chk("rst.busy", {7'b0, busy}, 8'h00);
        rst     = 1'b0;
        link_ak = 1'b0;
        req_rq  = 4'b1111;
        step();
        chk("rst.ptr", {4'b0, grant}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
